// File: rtl/arb_req_pkg.sv
// Shared types and helpers for the request/grant front end of an external fixed-priority arbiter.
package arb_req_pkg;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // One extra pointer bit separates full from empty when indices match.
  function automatic int ptr_w_f(input int depth);
    return clog2_f(depth) + 1;
  endfunction

  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_PTR_W      = ptr_w_f(DEF_FIFO_DEPTH);

endpackage

// File: rtl/arb_req_mux_if.sv
// Input streams, arbiter request/grant lines and the muxed output stream of arb_req_mux.
interface arb_req_mux_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64
);
  logic [NUM_REQ-1:0]        in_valid;
  logic [NUM_REQ-1:0]        in_ready;
  logic [NUM_REQ*DATA_W-1:0] in_data;
  logic [NUM_REQ-1:0]        request;
  logic                      arb_enable;
  logic [NUM_REQ-1:0]        single_mask;
  logic [NUM_REQ-1:0]        grant;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic [NUM_REQ-1:0]        out_src;

  // slave = arb_req_mux side, master = sources, sink and arbiter around it
  modport slave (
    input  in_valid, in_data, grant, out_ready,
    output in_ready, request, arb_enable, single_mask, out_valid, out_data, out_src
  );

  modport master (
    output in_valid, in_data, grant, out_ready,
    input  in_ready, request, arb_enable, single_mask, out_valid, out_data, out_src
  );
endinterface

// File: rtl/arb_req_fifo.sv
// Per-channel synchronous FIFO with a show-ahead head so a grant can pop and load in one cycle.
module arb_req_fifo
  import arb_req_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = ptr_w_f(FIFO_DEPTH);
  localparam int IDX_W = PTR_W - 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              push_ok, pop_ok;

  assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                 (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Full is judged on registered pointers, so a same-cycle pop never admits a push.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, pop_ok};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[IDX_W-1:0]] <= push_data;
  end

  assign head = mem_q[rd_ptr_q[IDX_W-1:0]];

endmodule

// File: rtl/arb_req_mux.sv
// Buffers NUM_REQ streams, requests an external fixed-priority arbiter, and muxes granted beats
// into one tagged output stream; a burst-lock FSM can pin the arbiter to one channel.
module arb_req_mux
  import arb_req_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_lock_en,
  output logic          err_grant,
  arb_req_mux_if.slave  bus
);
  localparam int CNT_W = clog2_f(BURST_LEN) + 1;

  logic [NUM_REQ-1:0] fifo_full, fifo_empty, fifo_nonempty, fifo_push, fifo_pop;
  logic [DATA_W-1:0]  fifo_head [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_fifo
      assign fifo_push[gi] = bus.in_valid[gi] & ~fifo_full[gi];

      arb_req_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push[gi]),
        .push_data (bus.in_data[gi*DATA_W +: DATA_W]),
        .pop       (fifo_pop[gi]),
        .head      (fifo_head[gi]),
        .full      (fifo_full[gi]),
        .empty     (fifo_empty[gi])
      );
    end
  endgenerate

  assign bus.in_ready  = ~fifo_full;
  assign fifo_nonempty = ~fifo_empty;

  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [NUM_REQ-1:0] out_src_q, out_src_d;
  logic               err_grant_q, err_grant_d;
  logic               slot_free, grant_onehot0, grant_legal, take;
  logic [DATA_W-1:0]  sel_data;

  assign slot_free   = ~out_valid_q | bus.out_ready;
  assign bus.request = fifo_nonempty & {NUM_REQ{slot_free}};

  // A grant is legal only if it is one-hot (or zero) and covers a raised request bit.
  assign grant_onehot0 = ((bus.grant & (bus.grant - {{(NUM_REQ-1){1'b0}}, 1'b1})) == '0);
  assign grant_legal   = grant_onehot0 && ((bus.grant & ~bus.request) == '0);
  assign take          = slot_free & grant_legal & (|bus.grant);
  assign fifo_pop      = take ? bus.grant : '0;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.grant[i]) sel_data = sel_data | fifo_head[i];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (take) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_src_d   = bus.grant;
    end else if (slot_free) begin
      out_valid_d = 1'b0;
    end
    err_grant_d = err_grant_q | ((|bus.grant) & ~grant_legal);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      err_grant_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      err_grant_q <= err_grant_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign err_grant     = err_grant_q;

  arb_state_t         state_q;
  logic [NUM_REQ-1:0] lock_ch_q;
  logic [CNT_W-1:0]   burst_cnt_q;
  logic               arb_enable_q;
  logic [NUM_REQ-1:0] single_mask_q;

  // Stalls (no slot_free) leave the lock and its count untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_ARB;
      lock_ch_q     <= '0;
      burst_cnt_q   <= '0;
      arb_enable_q  <= 1'b1;
      single_mask_q <= '0;
    end else begin
      case (state_q)
        ST_ARB: begin
          if (take && cfg_lock_en && (BURST_LEN > 1)) begin
            state_q       <= ST_LOCK;
            lock_ch_q     <= bus.grant;
            burst_cnt_q   <= CNT_W'(1);
            arb_enable_q  <= 1'b0;
            single_mask_q <= bus.grant;
          end
        end
        ST_LOCK: begin
          if (!cfg_lock_en ||
              (take && (burst_cnt_q == CNT_W'(BURST_LEN - 1))) ||
              (slot_free && ((fifo_nonempty & lock_ch_q) == '0))) begin
            state_q       <= ST_ARB;
            lock_ch_q     <= '0;
            burst_cnt_q   <= '0;
            arb_enable_q  <= 1'b1;
            single_mask_q <= '0;
          end else if (take) begin
            burst_cnt_q <= burst_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q       <= ST_ARB;
          arb_enable_q  <= 1'b1;
          single_mask_q <= '0;
        end
      endcase
    end
  end

  assign bus.arb_enable  = arb_enable_q;
  assign bus.single_mask = single_mask_q;

endmodule
